// File: rtl/recip_arb_pkg.sv
// -----------------------------------------------------------------------------
// recip_arb_pkg
// Shared definitions for the reciprocal-unit arbiter:
//   - arb_st_t : arbiter FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   - REC_W/REC_F : default operand width / fractional bits, shared with the
//                   reciprocal datapath so both sides agree on the QF format
//   - idx_w()  : index width for an N-entry vector (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package recip_arb_pkg;

    localparam int REC_W = 32;
    localparam int REC_F = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_st_t;

    // Width of an index into an n-entry vector; a 1-entry vector still gets 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/recip_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req upward from ptr with wrap and
// returns the first set position.
// Ports:
//   req [N-1:0]     request vector
//   ptr [IDX_W-1:0] search start position (must be < N)
//   gnt [N-1:0]     one-hot grant (all zero when no request)
//   idx [IDX_W-1:0] index of the granted position (0 when no request)
//   any             at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    // Walk candidates from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
                any       = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/recip_arbiter.sv
// -----------------------------------------------------------------------------
// recip_arbiter
// Shares one fixed-point reciprocal unit among N requesters. Requests are
// granted round-robin; each grant runs exactly one start/done transaction on
// the unit with the operand held stable, and the result is returned to the
// granted requester. Data is passed through untouched (F is format only).
//
// Optional feature: define RECIP_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYC cycles; on expiry the unit is aborted (rec_abort pulse) and an
// invalid, timed-out response is returned. Without it WAIT is unbounded and
// rec_abort / rsp_timeout stay 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid[N]        per-requester request, held until req_ready
//   req_x[N*W]          operands, requester i at [i*W +: W]
//   req_ready[N]        one-hot accept pulse (combinational in IDLE)
//   rsp_valid[N]        one-hot result pulse to the granted requester
//   rsp_data[W]         result, meaningful while rsp_valid != 0
//   rsp_invalid         result invalid (operand <= 0 or aborted)
//   rsp_timeout         result produced by abort
//   rec_start, rec_x    start pulse / operand to the reciprocal unit
//   rec_done, rec_result, rec_invalid   completion from the unit
//   rec_abort           one-cycle abort pulse (ORed into the unit's reset)
// -----------------------------------------------------------------------------
module recip_arbiter
    import recip_arb_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = REC_W,
    parameter int F           = REC_F,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_x,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_invalid,
    output logic           rsp_timeout,
    output logic           rec_start,
    output logic [W-1:0]   rec_x,
    input  logic           rec_done,
    input  logic [W-1:0]   rec_result,
    input  logic           rec_invalid,
    output logic           rec_abort
);

    localparam int IDX_W = idx_w(N);

    // Parameter sanity is structural only: an out-of-range set elaborates an
    // empty, clearly named block that shows up in the hierarchy.
    if ((N < 2) || (N > 8) || (F >= W) || (TIMEOUT_CYC < 1)) begin : g_cfg_out_of_range
    end

    arb_st_t          state_r;
    arb_st_t          state_s;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] grant_r;
    logic [W-1:0]     op_r;
    logic [W-1:0]     rsp_data_r;
    logic             rsp_inv_r;
    logic             rsp_to_r;
    logic [N-1:0]     rsp_valid_r;
    logic             rec_start_r;
    logic             rec_abort_r;
    logic             timeout_s;
    logic [N-1:0]     pick_gnt_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic [W-1:0]     sel_x_s;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Operand of the requester the picker currently selects.
    always_comb begin
        sel_x_s = req_x[pick_idx_s * W +: W];
    end

`ifdef RECIP_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_w(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_r;

    // Counts completed WAIT cycles of the current transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (state_r == ISSUE) begin
            wait_cnt_r <= '0;
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Fires in the TIMEOUT_CYC-th WAIT cycle; a done in that same cycle wins.
    assign timeout_s = (state_r == WAIT)
                    && (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1))
                    && !rec_done;
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; one transaction in flight at a time.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (rec_done || timeout_s) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: accept pulse is combinational so the requester sees it in the grant cycle.
    always_comb begin
        if (state_r == IDLE) begin
            req_ready = pick_gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    // Transaction datapath: grant/operand latch, unit handshake and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= '0;
            grant_r     <= '0;
            op_r        <= '0;
            rsp_data_r  <= '0;
            rsp_inv_r   <= 1'b0;
            rsp_to_r    <= 1'b0;
            rsp_valid_r <= '0;
            rec_start_r <= 1'b0;
            rec_abort_r <= 1'b0;
        end else begin
            rec_start_r <= 1'b0;
            rec_abort_r <= 1'b0;
            rsp_valid_r <= '0;
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        grant_r     <= pick_idx_s;
                        op_r        <= sel_x_s;
                        // Registered so the start pulse lines up with the ISSUE cycle.
                        rec_start_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (rec_done) begin
                        rsp_data_r <= rec_result;
                        rsp_inv_r  <= rec_invalid;
                        rsp_to_r   <= 1'b0;
                    end else if (timeout_s) begin
                        rsp_data_r  <= '0;
                        rsp_inv_r   <= 1'b1;
                        rsp_to_r    <= 1'b1;
                        rec_abort_r <= 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid_r <= {{(N-1){1'b0}}, 1'b1} << grant_r;
                    if (grant_r == IDX_W'(N - 1)) begin
                        ptr_r <= '0;
                    end else begin
                        ptr_r <= grant_r + IDX_W'(1);
                    end
                end
                default: begin
                    ptr_r <= ptr_r;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_invalid = rsp_inv_r;
    assign rsp_timeout = rsp_to_r;
    assign rec_start   = rec_start_r;
    assign rec_abort   = rec_abort_r;
    // The operand register is only written on accept, so rec_x stays stable
    // from ISSUE through RESP and holds in IDLE.
    assign rec_x       = op_r;

endmodule
